// File: rtl/acc_seq_pkg.sv
// Shared types for the accumulator sequencer: FSM state encoding and default field width.
package acc_seq_pkg;

    localparam int LEN_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/acc_seq_cnt.sv
// Clearable up-counter; an increment with wrap asserted returns it to zero instead of counting on.
module acc_seq_cnt
    import acc_seq_pkg::*;
#(
    parameter int W = LEN_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         wrap,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = wrap ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/acc_seq.sv
// Sequencer for an external registered accumulator: streams cfg_num reductions of cfg_len beats
// each and hands every finished sum downstream over valid/ready.
//
//   state | meaning
//   IDLE  | waiting for start; config is sampled here
//   ACCUM | taking operand beats and feeding the accumulator
//   DRAIN | one cycle for the accumulator register to absorb the last beat
//   OUT   | holding the captured sum until downstream accepts it
module acc_seq
    import acc_seq_pkg::*;
#(
    parameter int D_W     = 32,
    parameter int D_W_ACC = 32,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [LEN_W-1:0]   cfg_num,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    input  logic               in_valid,
    input  logic [D_W-1:0]     in_data,
    output logic               in_ready,
    output logic               acc_enable,
    output logic               acc_initialize,
    output logic [D_W-1:0]     acc_in_data,
    input  logic [D_W_ACC-1:0] acc_result,
    output logic               out_valid,
    output logic [D_W_ACC-1:0] out_data,
    input  logic               out_ready
);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_m1_q, len_m1_d;
    logic [LEN_W-1:0]   num_m1_q, num_m1_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;
    logic               out_valid_q, out_valid_d;
    logic [D_W_ACC-1:0] out_data_q, out_data_d;

    logic             fire;
    logic             cnt_clr;
    logic             beat_inc;
    logic             red_inc;
    logic             beat_last;
    logic             red_last;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] red_cnt;

    assign in_ready       = (state_q == ACCUM);
    assign fire           = in_valid & in_ready;
    assign acc_enable     = fire;
    assign acc_initialize = fire & (beat_cnt == '0);
    assign acc_in_data    = in_data;

    // Lengths are stored minus one so a full-width cfg_len still fits the counter.
    assign beat_last = (beat_cnt == len_m1_q);
    assign red_last  = (red_cnt == num_m1_q);

    acc_seq_cnt #(.W(LEN_W)) u_beat_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (beat_inc),
        .wrap (beat_last),
        .cnt  (beat_cnt)
    );

    acc_seq_cnt #(.W(LEN_W)) u_red_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (red_inc),
        .wrap (red_last),
        .cnt  (red_cnt)
    );

    always_comb begin
        state_d     = state_q;
        len_m1_d    = len_m1_q;
        num_m1_d    = num_m1_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        cnt_clr     = 1'b0;
        beat_inc    = 1'b0;
        red_inc     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if ((cfg_len != '0) && (cfg_num != '0)) begin
                        len_m1_d = cfg_len - LEN_W'(1);
                        num_m1_d = cfg_num - LEN_W'(1);
                        cnt_clr  = 1'b1;
                        state_d  = ACCUM;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (fire) begin
                    beat_inc = 1'b1;
                    if (beat_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                out_data_d  = acc_result;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    red_inc     = 1'b1;
                    if (red_last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_m1_q    <= '0;
            num_m1_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_m1_q    <= len_m1_d;
            num_m1_q    <= num_m1_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_acc_seq.sv
// Bench for acc_seq: drives jobs against a behavioural accumulator and checks sums and handshakes.
module tb_acc_seq;

    logic               clk;
    logic               rst;
    logic               start;
    logic [15:0]        cfg_len;
    logic [15:0]        cfg_num;
    logic               busy;
    logic               done;
    logic               cfg_err;
    logic               in_valid;
    logic [31:0]        in_data;
    logic               in_ready;
    logic               acc_enable;
    logic               acc_initialize;
    logic [31:0]        acc_in_data;
    logic [31:0]        acc_result;
    logic               out_valid;
    logic [31:0]        out_data;
    logic               out_ready;

    acc_seq #(.D_W(32), .D_W_ACC(32), .LEN_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_len        (cfg_len),
        .cfg_num        (cfg_num),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .acc_enable     (acc_enable),
        .acc_initialize (acc_initialize),
        .acc_in_data    (acc_in_data),
        .acc_result     (acc_result),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External accumulator: registered, initialize loads the operand instead of adding it.
    logic [31:0] acc_q;
    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else if (acc_enable) acc_q <= acc_initialize ? acc_in_data : acc_q + acc_in_data;
    end
    assign acc_result = acc_q;

    int n_chk;
    int n_pass;

    logic signed [31:0] beats[$];
    logic signed [31:0] got[$];
    int bad_en, bad_init, bad_lat, bad_stable, bad_overlap, bad_busy;
    int n_done, n_err, timeouts, busy_after;

    // Reference: a reduction's sum is the plain 32-bit wrapped sum of its beats.
    function automatic logic signed [31:0] ref_sum(input int r, input int len);
        logic signed [31:0] s;
        s = 0;
        for (int k = 0; k < len; k++) s += beats[r * len + k];
        return s;
    endfunction

    task automatic run_job(input int len, input int num, input int bubble, input int stall_pct,
                           input int hold, input int inject_at);
        int   fired;
        int   cyc;
        int   idx;
        int   budget;
        int   last_fire;
        int   hold_left;
        logic first_rise;
        logic prev_ov;
        logic prev_or;
        logic [31:0] prev_od;
        logic fire_s;
        fired = 0; cyc = 0; idx = 0; last_fire = -10; hold_left = 0;
        first_rise = 1'b0; prev_ov = 1'b0; prev_or = 1'b1; prev_od = '0;
        got.delete();
        bad_en = 0; bad_init = 0; bad_lat = 0; bad_stable = 0; bad_overlap = 0; bad_busy = 0;
        n_done = 0; n_err = 0; timeouts = 0; busy_after = 0;
        budget = (len + 6) * num * 16 + hold + 50;

        @(posedge clk); #1;
        start = 1'b1; cfg_len = 16'(len); cfg_num = 16'(num); in_valid = 1'b0; out_ready = 1'b1;

        while (n_done == 0 && cyc < budget) begin
            @(posedge clk); #1;
            start   = 1'b0;
            cfg_len = 16'($urandom);
            cfg_num = 16'($urandom);
            in_valid = (idx < beats.size()) &&
                       (bubble == 0 || (bubble == 1 ? (cyc % 2 == 0) : ($urandom_range(0, 1) == 1)));
            in_data  = (idx < beats.size()) ? beats[idx] : 32'($urandom);
            if (hold > 0 && !first_rise) begin
                out_ready = 1'b0;
            end else if (hold_left > 0) begin
                out_ready = 1'b0;
                hold_left--;
            end else begin
                out_ready = ($urandom_range(0, 99) >= stall_pct);
            end

            @(negedge clk);
            fire_s = in_valid && in_ready;
            if (acc_enable !== fire_s) bad_en++;
            if (fire_s) begin
                if (acc_initialize !== (fired % len == 0)) bad_init++;
                fired++;
                idx++;
                if (fired % len == 0) last_fire = cyc;
            end else if (acc_initialize !== 1'b0) begin
                bad_init++;
            end
            if (out_valid && !prev_ov) begin
                if (cyc != last_fire + 2) bad_lat++;
                if (!first_rise) begin
                    first_rise = 1'b1;
                    hold_left  = (hold > 0) ? hold - 1 : 0;
                end
            end
            if (prev_ov && !prev_or && (!out_valid || out_data !== prev_od)) bad_stable++;
            if (out_valid && in_ready) bad_overlap++;
            if (busy !== !done) bad_busy++;
            if (out_valid && out_ready) got.push_back(out_data);
            if (done) n_done++;
            if (cfg_err) n_err++;
            prev_ov = out_valid;
            prev_or = out_ready;
            prev_od = out_data;
            if (cyc == inject_at && busy) begin
                start   = 1'b1;
                cfg_len = 16'd1;
                cfg_num = 16'd1;
            end
            cyc++;
        end
        if (n_done == 0) timeouts++;

        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        if (busy || done || cfg_err) busy_after++;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_num = '0;
        in_valid = 1'b1; in_data = 32'hdead_beef; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({busy, done, cfg_err, in_ready, acc_enable, acc_initialize, out_valid, out_data} !== '0)
            $display("FAIL reset_outputs got=%b_%h required all zero",
                     {busy, done, cfg_err, in_ready, acc_enable, acc_initialize, out_valid}, out_data);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_basic;
        beats = '{1, 2, 3, 4};
        run_job(4, 1, 0, 0, 0, -1);
        n_chk++;
        if (got.size() != 1 || got[0] !== 32'sd10)
            $display("FAIL basic_sum got_n=%0d got=%0d required n=1 sum=10", got.size(),
                     got.size() > 0 ? got[0] : 0);
        else n_pass++;
        n_chk++;
        if (bad_init != 0 || bad_lat != 0 || bad_en != 0)
            $display("FAIL basic_timing init_err=%0d lat_err=%0d en_err=%0d required 0 0 0",
                     bad_init, bad_lat, bad_en);
        else n_pass++;
        n_chk++;
        if (n_done != 1 || busy_after != 0 || timeouts != 0)
            $display("FAIL basic_done done=%0d busy_after=%0d timeout=%0d required 1 0 0",
                     n_done, busy_after, timeouts);
        else n_pass++;
    endtask

    task automatic test_multi;
        beats = '{5, -2, 7, -1, -1, -1};
        run_job(3, 2, 0, 0, 0, -1);
        n_chk++;
        if (got.size() != 2 || got[0] !== 32'sd10 || got[1] !== -32'sd3)
            $display("FAIL multi_sums got_n=%0d first=%0d second=%0d required 10 then -3", got.size(),
                     got.size() > 0 ? got[0] : 0, got.size() > 1 ? got[1] : 0);
        else n_pass++;
        n_chk++;
        if (n_done != 1 || busy_after != 0 || bad_busy != 0 || bad_lat != 0 || bad_init != 0)
            $display("FAIL multi_protocol done=%0d busy_after=%0d busy_err=%0d lat_err=%0d init_err=%0d required 1 0 0 0 0",
                     n_done, busy_after, bad_busy, bad_lat, bad_init);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        beats = '{100, -7, 40, 2};
        run_job(2, 2, 0, 0, 5, -1);
        n_chk++;
        if (got.size() != 2 || got[0] !== 32'sd93 || got[1] !== 32'sd42)
            $display("FAIL bp_sums got_n=%0d first=%0d second=%0d required 93 then 42", got.size(),
                     got.size() > 0 ? got[0] : 0, got.size() > 1 ? got[1] : 0);
        else n_pass++;
        n_chk++;
        if (bad_stable != 0 || bad_overlap != 0 || bad_en != 0)
            $display("FAIL bp_hold stable_err=%0d overlap=%0d en_err=%0d required 0 0 0",
                     bad_stable, bad_overlap, bad_en);
        else n_pass++;
    endtask

    task automatic test_bubbles;
        beats = '{7, 8, 9, 10};
        run_job(4, 1, 1, 0, 0, -1);
        n_chk++;
        if (got.size() != 1 || got[0] !== 32'sd34)
            $display("FAIL bubble_sum got_n=%0d got=%0d required n=1 sum=34", got.size(),
                     got.size() > 0 ? got[0] : 0);
        else n_pass++;
        n_chk++;
        if (bad_en != 0 || bad_init != 0 || bad_lat != 0)
            $display("FAIL bubble_enable en_err=%0d init_err=%0d lat_err=%0d required 0 0 0",
                     bad_en, bad_init, bad_lat);
        else n_pass++;
    endtask

    task automatic test_len_one;
        beats = '{-5, 12, 2147483647};
        run_job(1, 3, 0, 0, 0, -1);
        n_chk++;
        if (got.size() != 3 || got[0] !== -32'sd5 || got[1] !== 32'sd12 || got[2] !== 32'sd2147483647)
            $display("FAIL len1_sums got_n=%0d required 3 results -5 12 2147483647", got.size());
        else n_pass++;
        n_chk++;
        if (bad_init != 0 || n_done != 1)
            $display("FAIL len1_init init_err=%0d done=%0d required 0 1", bad_init, n_done);
        else n_pass++;
    endtask

    task automatic test_cfg_err;
        @(posedge clk); #1;
        start = 1'b1; cfg_len = 16'd0; cfg_num = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_chk++;
        if (cfg_err !== 1'b1 || busy !== 1'b0)
            $display("FAIL cfg_err_len0 cfg_err=%b busy=%b required 1 0", cfg_err, busy);
        else n_pass++;
        @(posedge clk); #1;
        start = 1'b1; cfg_len = 16'd3; cfg_num = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_chk++;
        if (cfg_err !== 1'b1 || busy !== 1'b0)
            $display("FAIL cfg_err_num0 cfg_err=%b busy=%b required 1 0", cfg_err, busy);
        else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_chk++;
        if (cfg_err !== 1'b0 || busy !== 1'b0)
            $display("FAIL cfg_err_pulse cfg_err=%b busy=%b required 0 0", cfg_err, busy);
        else n_pass++;

        beats.delete();
        for (int i = 0; i < 6; i++) beats.push_back(32'($urandom));
        run_job(3, 2, 0, 0, 0, 2);
        n_chk++;
        if (got.size() != 2 || got[0] !== ref_sum(0, 3) || got[1] !== ref_sum(1, 3))
            $display("FAIL ignore_start got_n=%0d first=%0d required n=2 first=%0d", got.size(),
                     got.size() > 0 ? got[0] : 0, ref_sum(0, 3));
        else n_pass++;
        n_chk++;
        if (n_err != 0 || n_done != 1)
            $display("FAIL ignore_start_err cfg_err=%0d done=%0d required 0 1", n_err, n_done);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        start = 1'b1; cfg_len = 16'd4; cfg_num = 16'd1; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 32'd11;
        @(posedge clk); #1;
        in_data = 32'd22; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({busy, done, cfg_err, in_ready, acc_enable, acc_initialize, out_valid, out_data} !== '0)
            $display("FAIL reset_mid_outputs got=%b_%h required all zero",
                     {busy, done, cfg_err, in_ready, acc_enable, acc_initialize, out_valid}, out_data);
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        beats = '{3, 4};
        run_job(2, 1, 0, 0, 0, -1);
        n_chk++;
        if (got.size() != 1 || got[0] !== 32'sd7)
            $display("FAIL reset_mid_fresh got_n=%0d got=%0d required n=1 sum=7", got.size(),
                     got.size() > 0 ? got[0] : 0);
        else n_pass++;
    endtask

    task automatic test_random;
        for (int j = 0; j < 10; j++) begin
            int len;
            int num;
            int nbad;
            len = $urandom_range(1, 6);
            num = $urandom_range(1, 4);
            beats.delete();
            for (int i = 0; i < len * num; i++) beats.push_back(32'($urandom));
            run_job(len, num, 2, 40, 0, $urandom_range(0, 8));
            nbad = 0;
            for (int r = 0; r < num; r++)
                if (r >= got.size() || got[r] !== ref_sum(r, len)) nbad++;
            n_chk++;
            if (got.size() != num || nbad != 0)
                $display("FAIL random_sums job=%0d len=%0d num=%0d got_n=%0d wrong=%0d required n=%0d wrong=0",
                         j, len, num, got.size(), nbad, num);
            else n_pass++;
            n_chk++;
            if (bad_en + bad_init + bad_lat + bad_stable + bad_overlap + bad_busy + n_err + timeouts + busy_after != 0
                || n_done != 1)
                $display("FAIL random_protocol job=%0d en=%0d init=%0d lat=%0d stable=%0d overlap=%0d busy=%0d err=%0d to=%0d after=%0d done=%0d required zeros and done=1",
                         j, bad_en, bad_init, bad_lat, bad_stable, bad_overlap, bad_busy, n_err,
                         timeouts, busy_after, n_done);
            else n_pass++;
        end
    endtask

    task automatic test_max_len;
        beats.delete();
        for (int i = 0; i < 65535; i++) beats.push_back(32'($urandom));
        run_job(65535, 1, 0, 0, 0, -1);
        n_chk++;
        if (got.size() != 1 || got[0] !== ref_sum(0, 65535))
            $display("FAIL max_len_sum got_n=%0d got=%0d required n=1 sum=%0d", got.size(),
                     got.size() > 0 ? got[0] : 0, ref_sum(0, 65535));
        else n_pass++;
        n_chk++;
        if (bad_init != 0 || bad_lat != 0 || n_done != 1)
            $display("FAIL max_len_protocol init_err=%0d lat_err=%0d done=%0d required 0 0 1",
                     bad_init, bad_lat, n_done);
        else n_pass++;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_num = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        test_reset;
        test_basic;
        test_multi;
        test_backpressure;
        test_bubbles;
        test_len_one;
        test_cfg_err;
        test_reset_mid;
        test_random;
        test_max_len;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/acc_seq.md
Name: acc_seq

Overview:
- Sequencer for one external signed accumulator (enable/initialize/result style) used in the matmul/attention datapath.
- Runs a job of `cfg_num` reductions, each of `cfg_len` input beats.
- Per reduction: streams operands into the accumulator, then captures the finished sum and presents it on a valid/ready output.
- Sits between the operand stream (e.g. from the MAC/product stage) and the writeback/requantise stage.

Parameters:
- D_W, 32, width of input operand stream.
- D_W_ACC, 32, width of accumulator result and output data.
- LEN_W, 16, width of reduction-length and reduction-count config fields.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle job request; sampled only in IDLE
- cfg_len  in  LEN_W  beats per reduction; sampled with start
- cfg_num  in  LEN_W  reductions per job; sampled with start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse after last result is accepted
- cfg_err  out  1  one-cycle pulse when start is rejected (len==0 or num==0)
- in_valid  in  1  operand valid
- in_data  in  D_W  signed operand
- in_ready  out  1  high only in ACCUM
- acc_enable  out  1  to accumulator enable
- acc_initialize  out  1  to accumulator initialize
- acc_in_data  out  D_W  to accumulator in_data
- acc_result  in  D_W_ACC  from accumulator result (registered, 1-cycle latency)
- out_valid  out  1  result valid
- out_data  out  D_W_ACC  captured signed sum
- out_ready  in  1  downstream accept

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - State IDLE.
  - busy, done, cfg_err, in_ready, acc_enable, acc_initialize, out_valid all 0.
  - out_data 0; internal counters 0.
- States: IDLE, ACCUM, DRAIN, OUT.
- IDLE:
  - start with cfg_len != 0 and cfg_num != 0: latch both, clear beat_cnt and red_cnt, go ACCUM.
  - start with either field 0: pulse cfg_err next cycle, stay IDLE.
- ACCUM:
  - in_ready = 1.
  - Fire = in_valid & in_ready.
  - acc_enable = fire (combinational). acc_initialize = fire & (beat_cnt == 0). acc_in_data = in_data (pass-through).
  - On fire: beat_cnt++.
  - On fire with beat_cnt == len-1: clear beat_cnt, go DRAIN.
  - No fire means no accumulator activity and the state holds.
- DRAIN:
  - Exactly one cycle; acc_enable = 0. Lets the registered accumulator absorb the last beat.
  - On exit: out_data <= acc_result, out_valid <= 1, go OUT.
- OUT:
  - out_valid and out_data stay stable until out_ready.
  - On out_valid & out_ready: out_valid <= 0, red_cnt++.
  - If red_cnt == num-1: done pulses 1 cycle and next state is IDLE. Otherwise go ACCUM.
  - in_ready = 0 in OUT (no overlap; back-pressure reaches the input stream).
- Latency:
  - Last input beat to out_valid = 2 cycles.
  - Back-to-back reductions with out_ready tied 1: 1 bubble cycle of in_ready in DRAIN and 1 in OUT.
- Arithmetic: the block does no arithmetic on data; overflow/wrap is the accumulator's concern. Counters are LEN_W bits; cfg_len up to 2^LEN_W-1 must work.
- Simultaneous events:
  - start outside IDLE is ignored: no error, config unchanged.
  - cfg changes mid-job have no effect.
- Mid-operation reset: any state returns to IDLE next edge with all outputs at reset values. The accumulator is reset by the same rst.
- len == 1: every beat asserts acc_initialize.
- out_ready held high during DRAIN has no effect until OUT.

Decomposition:
- Shared package `acc_seq_pkg`: state enum type (IDLE, ACCUM, DRAIN, OUT) and default LEN_W.
- A small sub-module `acc_seq_cnt` (load/increment/terminal-count counter, LEN_W wide) is natural and is instantiated twice, for beats and reductions.
- The FSM stays in the top.

Test Plan:
- Basic reduction:
  - Stimulus: start len=4, num=1; inputs 1,2,3,4 with in_valid always 1; out_ready=1.
  - Required: out_data=10 two cycles after beat 4, then done pulse.
  - Required: acc_initialize high only on beat 1.
- Multiple reductions:
  - Stimulus: len=3, num=2; inputs 5,-2,7 then -1,-1,-1.
  - Required: outputs 10 then -3 in order; then done; busy low afterwards.
- Back-pressure:
  - Stimulus: len=2, num=2, out_ready held 0 for 5 cycles.
  - Required: out_valid and out_data stable; in_ready 0 throughout; no acc_enable pulses.
  - Required: after release, second result is correct.
- Input bubbles:
  - Stimulus: len=4 with in_valid toggling 1,0,1,0,...
  - Required: acc_enable mirrors fire only; sum is correct.
- Config error / ignore:
  - Stimulus: start with len=0 gives a cfg_err pulse and stays IDLE. start asserted during ACCUM is ignored.
  - Required: job completes per the original config.
- Reset mid-job:
  - Stimulus: assert rst during ACCUM beat 2 of len=4.
  - Required: next cycle IDLE with all outputs 0.
  - Required: a fresh job (len=2: 3,4) yields 7.
